// File: rtl/key_debounce_if.sv
// Push-button signal bundle: raw key level towards the debouncer,
// debounced level and press/release strobes back to the consumer.
interface key_debounce_if;
    logic key_raw;
    logic pressed;
    logic press_pulse;
    logic release_pulse;

    // Key source / event consumer side
    modport master (
        output key_raw,
        input  pressed,
        input  press_pulse,
        input  release_pulse
    );

    // Debouncer side
    modport slave (
        input  key_raw,
        output pressed,
        output press_pulse,
        output release_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button debouncer.
// The raw key is synchronised through a short flip-flop chain. A four-state
// FSM then accepts a level change only after STABLE_CYCLES consecutive
// identical samples. The outputs are a registered debounced level and
// single-cycle press/release strobes.
module key_debounce #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    key_debounce_if.slave bus
);

    localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    // Synchroniser reset level: whatever the pin shows when the key is idle
    localparam logic INACTIVE_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             pressed_reg;
    logic             press_pulse_reg;
    logic             release_pulse_reg;
    logic             sync;
    logic             act;

    // Synchroniser chain. Each stage is its own flop so that the chain depth
    // follows SYNC_STAGES.
    for (genvar gi = 0; gi < int'(SYNC_STAGES); gi++) begin : g_sync
        logic stage_reg;
        if (gi == 0) begin : g_first
            // First stage captures the asynchronous pin
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stage_reg <= INACTIVE_LVL;
                else     stage_reg <= bus.key_raw;
            end
        end else begin : g_next
            // Later stages shift the previous stage along
            always_ff @(posedge clk or posedge rst) begin
                if (rst) stage_reg <= INACTIVE_LVL;
                else     stage_reg <= g_sync[gi-1].stage_reg;
            end
        end
    end

    assign sync = g_sync[SYNC_STAGES-1].stage_reg;
    // act = 1 means "key is physically held" regardless of pin polarity
    assign act  = sync ^ ACTIVE_LOW;

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= UP;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic. The counter only runs in the two WAIT states and is
    // cleared on every state change, so it never passes CNT_MAX.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        unique case (state_reg)
            UP: begin
                if (act) begin
                    state_next = WAIT_DOWN;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_DOWN: begin
                if (!act) begin
                    state_next = UP;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = DOWN;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            DOWN: begin
                if (!act) begin
                    state_next = WAIT_UP;
                    cnt_next   = CNT_W'(1);
                end
            end
            WAIT_UP: begin
                if (act) begin
                    state_next = DOWN;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = UP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = UP;
            end
        endcase
    end

    // Registered outputs. They are decoded from the next state so that the
    // level and the strobes change on the same edge as the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pressed_reg       <= 1'b0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
        end else begin
            pressed_reg       <= (state_next == DOWN) || (state_next == WAIT_UP);
            press_pulse_reg   <= (state_reg == WAIT_DOWN) && (state_next == DOWN);
            release_pulse_reg <= (state_reg == WAIT_UP) && (state_next == UP);
        end
    end

    assign bus.pressed       = pressed_reg;
    assign bus.press_pulse   = press_pulse_reg;
    assign bus.release_pulse = release_pulse_reg;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce (STABLE_CYCLES=8, SYNC_STAGES=2, active-low key).
// The stimulus pushes hand-computed pulse events (kind, cycle) into a queue.
// A negedge monitor pops one event for each DUT strobe and compares it.
// The monitor also checks the debounced level on every cycle against a
// run-length filter of the synchronised input.
module tb_key_debounce;
    localparam int STABLE = 8;
    localparam int SYNC   = 2;
    localparam int LAT    = SYNC + STABLE;

    typedef struct {
        bit          kind;   // 1 = press, 0 = release
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];

    key_debounce_if bus();

    key_debounce #(
        .STABLE_CYCLES(STABLE),
        .SYNC_STAGES  (SYNC),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Edge counter: after edge N (seen #1 later or at the negedge) cyc == N
    always @(posedge clk) cyc <= cyc + 1;

    // Reference level: flips after STABLE consecutive synchronised samples
    // that disagree with the current level
    logic m_s1 = 1'b1;
    logic m_s2 = 1'b1;
    logic m_pressed = 1'b0;
    int   m_run = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1      <= 1'b1;
            m_s2      <= 1'b1;
            m_pressed <= 1'b0;
            m_run     <= 0;
        end else begin
            m_s1 <= bus.key_raw;
            m_s2 <= m_s1;
            if (!m_s2 != m_pressed) begin
                if (m_run == STABLE - 1) begin
                    m_pressed <= !m_s2;
                    m_run     <= 0;
                end else begin
                    m_run <= m_run + 1;
                end
            end else begin
                m_run <= 0;
            end
        end
    end

    // Monitor: level check, pulse exclusivity, scoreboard pop
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (bus.pressed !== m_pressed) begin
            failures++;
            $display("FAIL pressed_model cyc=%0d actual=%b required=%b", cyc, bus.pressed, m_pressed);
        end
        checks++;
        if (bus.press_pulse === 1'b1 && bus.release_pulse === 1'b1) begin
            failures++;
            $display("FAIL pulse_overlap cyc=%0d actual=11 required=not both", cyc);
        end
        if (bus.press_pulse === 1'b1 || bus.release_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse cyc=%0d actual press=%b release=%b required=none",
                         cyc, bus.press_pulse, bus.release_pulse);
            end else begin
                e = exp_q.pop_front();
                if (e.kind != bus.press_pulse || e.cyc != cyc) begin
                    failures++;
                    $display("FAIL pulse_match actual kind=%0d cyc=%0d required kind=%0d cyc=%0d",
                             bus.press_pulse, cyc, e.kind, e.cyc);
                end else begin
                    $display("pulse %s at cycle %0d ok", e.kind ? "press" : "release", cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL missed_pulse actual=none at cyc %0d required kind=%0d cyc=%0d",
                     cyc, e.kind, e.cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_pulse(input bit kind, input int unsigned at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic actual, input logic required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", name, cyc, actual, required);
        end
    endtask

    int holds[16] = '{3, 1, 5, 2, 7, 4, 1, 6, 2, 3, 5, 1, 4, 7, 2, 7};
    int unsigned base;

    initial begin
        rst         = 1'b1;
        bus.key_raw = 1'b1;
        tick(2);
        check_bit("reset_pressed", bus.pressed, 1'b0);
        check_bit("reset_press_pulse", bus.press_pulse, 1'b0);
        check_bit("reset_release_pulse", bus.release_pulse, 1'b0);
        rst = 1'b0;

        // Idle key for 20 cycles
        tick(20);
        check_bit("idle_pressed", bus.pressed, 1'b0);

        // Clean press, first sampled at edge base+1
        bus.key_raw = 1'b0;
        base = cyc;
        expect_pulse(1'b1, base + LAT);
        tick(LAT - 1);
        check_bit("press_early", bus.pressed, 1'b0);
        tick(1);
        check_bit("press_level", bus.pressed, 1'b1);
        check_bit("press_pulse_hi", bus.press_pulse, 1'b1);
        tick(1);
        check_bit("press_pulse_lo", bus.press_pulse, 1'b0);
        tick(5);

        // Clean release
        bus.key_raw = 1'b1;
        expect_pulse(1'b0, cyc + LAT);
        tick(LAT + 4);

        // Bounce: alternating segments of 1..7 cycles, ending high, then stable low
        for (int i = 0; i < 16; i++) begin
            bus.key_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(holds[i]);
        end
        bus.key_raw = 1'b0;
        expect_pulse(1'b1, cyc + LAT);
        tick(LAT + 4);

        // Release with a 3-cycle low glitch in mid-debounce
        bus.key_raw = 1'b1;
        tick(3);
        bus.key_raw = 1'b0;
        tick(3);
        bus.key_raw = 1'b1;
        expect_pulse(1'b0, cyc + LAT);
        tick(LAT + 4);

        // Low glitch one sample short of the threshold: no press
        bus.key_raw = 1'b0;
        tick(STABLE - 1);
        bus.key_raw = 1'b1;
        tick(12);
        check_bit("short_glitch_pressed", bus.pressed, 1'b0);

        // Low pulse of exactly STABLE cycles: accepted, then released
        bus.key_raw = 1'b0;
        expect_pulse(1'b1, cyc + LAT);
        tick(STABLE);
        bus.key_raw = 1'b1;
        expect_pulse(1'b0, cyc + LAT);
        tick(LAT + 4);

        // Reset mid-debounce; the key stays low through and after reset
        bus.key_raw = 1'b0;
        tick(5);
        rst = 1'b1;
        #1;
        check_bit("rst_mid_pressed", bus.pressed, 1'b0);
        check_bit("rst_mid_pulse", bus.press_pulse, 1'b0);
        tick(2);
        rst = 1'b0;
        expect_pulse(1'b1, cyc + LAT);
        tick(LAT + 4);
        check_bit("after_rst_pressed", bus.pressed, 1'b1);

        // Reset while held: level drops at once and no release strobe appears
        rst = 1'b1;
        #1;
        check_bit("rst_down_pressed", bus.pressed, 1'b0);
        check_bit("rst_down_release", bus.release_pulse, 1'b0);
        tick(3);
        rst = 1'b0;
        expect_pulse(1'b1, cyc + LAT);
        tick(LAT + 30);

        // Final release, then hold released for a while
        bus.key_raw = 1'b1;
        expect_pulse(1'b0, cyc + LAT);
        tick(LAT + 30);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_pulses actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter STABLE_CYCLES, default 1000000: consecutive identical synchronized samples required to accept a level change (20 ms at 50 MHz); legal range 2..2^24.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flip-flop depth on the raw input; legal range 2..4.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = key_raw low means pressed; 0 = key_raw high means pressed.
REQ-004 clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key_raw  input  1  asynchronous, bouncing push-button level.
REQ-007 pressed  output  1  debounced level, 1 = key held.
REQ-008 press_pulse  output  1  single-cycle strobe on accepted press.
REQ-009 release_pulse  output  1  single-cycle strobe on accepted release.

Function
REQ-010 key_raw SHALL pass through a SYNC_STAGES-deep flip-flop chain; only the last stage output (sync) feeds the logic; act = sync XOR ACTIVE_LOW.
REQ-011 FSM SHALL have four states: UP, WAIT_DOWN, DOWN, WAIT_UP; counter cnt width = clog2(STABLE_CYCLES).
REQ-012 UP: act=1 -> WAIT_DOWN, cnt<=1; else stay, cnt<=0.
REQ-013 WAIT_DOWN: act=0 -> UP, cnt<=0; act=1 and cnt==STABLE_CYCLES-1 -> DOWN, cnt<=0; else cnt<=cnt+1.
REQ-014 DOWN: act=0 -> WAIT_UP, cnt<=1; else stay, cnt<=0.
REQ-015 WAIT_UP: act=1 -> DOWN, cnt<=0; act=0 and cnt==STABLE_CYCLES-1 -> UP, cnt<=0; else cnt<=cnt+1.
REQ-016 pressed SHALL be registered, 1 exactly in states DOWN and WAIT_UP.
REQ-017 press_pulse SHALL be registered, high for exactly one cycle, coincident with the first cycle pressed=1.
REQ-018 release_pulse SHALL be registered, high for exactly one cycle, coincident with the first cycle pressed=0 after a press.
REQ-019 Latency: with key_raw changing cleanly and first sampled at rising edge 1, pressed/pulse SHALL change after rising edge SYNC_STAGES+STABLE_CYCLES.
REQ-020 Any glitch shorter than STABLE_CYCLES synchronized cycles SHALL cause no change on pressed and no pulse; the counter restarts from the next qualifying sample.
REQ-021 cnt SHALL never exceed STABLE_CYCLES-1 and never wrap.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle; consecutive pulses SHALL alternate press, release, press.
REQ-023 Input held constant for any duration SHALL produce at most one pulse.

Reset
REQ-024 rst=1 SHALL immediately force state UP, cnt=0, pressed=0, press_pulse=0, release_pulse=0, and all synchronizer stages to the inactive level (ACTIVE_LOW ? 1 : 0).
REQ-025 Reset asserted mid-debounce (WAIT_DOWN, WAIT_UP) or in DOWN SHALL discard progress and emit no pulse, during or after reset.
REQ-026 After rst deasserts with key_raw already active, a press SHALL be accepted after the full REQ-019 latency, with press_pulse emitted.

Verification (STABLE_CYCLES=8, SYNC_STAGES=2, ACTIVE_LOW=1)
REQ-027 Reset, key_raw=1 for 20 cycles -> pressed=0, no pulses throughout.
REQ-028 Clean press: key_raw 1->0 first sampled at edge 1 -> pressed=1 and press_pulse=1 after edge 10; press_pulse=0 after edge 11.
REQ-029 Bounce: key_raw toggles 0/1 with random hold times of 1..7 cycles for 60 cycles, then held 0 -> exactly one press_pulse, 10 edges after the final stable 0 is first sampled.
REQ-030 Release: from pressed, key_raw 0->1 with a 3-cycle low glitch in mid-debounce -> release_pulse exactly once, after edge 10 counted from the last 1 following the glitch.
REQ-031 Reset mid-debounce: key_raw=0, rst pulsed after 5 cycles, key_raw held 0 -> no pulse during reset, press_pulse after edge 10 counted from rst deassertion.
REQ-032 Scoreboard on all random runs: pulses alternate, each pulse lasts exactly one cycle, pressed equals a reference model filtering the synchronized input.
